// File: rtl/hazard_pkg.sv
// hazard_pkg: definitions shared by the hazard scoreboard and the decoder.
//   stall_cause_e : bit positions inside the stall_cause output vector
//   LAT_*         : extra result latency beyond a single-cycle ALU op
package hazard_pkg;

  typedef enum logic [1:0] {
    CAUSE_RAW    = 2'd0,
    CAUSE_WAW    = 2'd1,
    CAUSE_STRUCT = 2'd2
  } stall_cause_e;

  localparam int CAUSE_W  = 3;

  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_MUL  = 3;

endpackage

// File: rtl/scoreboard_entry.sv
// scoreboard_entry: pending-result state for one architectural register.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : variable-latency result for this register written back
//   load      : an instruction writing this register issues this cycle
//   load_cnt  : countdown to reload (cycles until forwardable)
//   load_var  : new producer is variable-latency
//   cnt       : remaining cycles before the result can be forwarded
//   is_var    : variable-latency producer outstanding
module scoreboard_entry
  import hazard_pkg::*;
#(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [LAT_W-1:0] load_cnt,
  input  logic             load_var,
  output logic [LAT_W-1:0] cnt,
  output logic             is_var
);

  // A new issue overrides both the countdown and a same-cycle writeback
  // clear, so a fresh variable-latency producer is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      is_var <= 1'b0;
    end else if (load) begin
      cnt    <= load_cnt;
      is_var <= load_var;
    end else begin
      // A variable-latency entry holds its count; it only retires by clr.
      if (cnt != '0 && !is_var) begin
        cnt <= cnt - 1'b1;
      end
      if (clr) begin
        is_var <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard beside the ID stage.
// Detects RAW, WAW and shared-unit structural hazards for the instruction
// in ID and stalls PC / IF-ID while bubbling ID/EX.
//   id_*            : instruction currently in ID
//   mdu_busy        : shared multi-cycle unit cannot accept
//   wb_done, wb_rd  : variable-latency result retired this cycle
//   flush_id        : ID instruction squashed, never issues
//   stall_pc, stall_if_id, flush_id_ex : combinational stall controls
//   stall_cause     : {structural, waw, raw}, zero when not stalling
//   stall_cycles    : count of stalled cycles (wraps)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int REG_W        = 5,
  parameter int LAT_W        = 3,
  parameter int BRANCH_IN_ID = 1,
  parameter int PERF_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic               id_is_branch,
  input  logic               id_reg_write,
  input  logic [REG_W-1:0]   id_rd,
  input  logic [LAT_W-1:0]   id_latency,
  input  logic               id_var_lat,
  input  logic               id_uses_mdu,
  input  logic               mdu_busy,
  input  logic               wb_done,
  input  logic [REG_W-1:0]   wb_rd,
  input  logic               flush_id,
  output logic               stall_pc,
  output logic               stall_if_id,
  output logic               flush_id_ex,
  output logic [CAUSE_W-1:0] stall_cause,
  output logic [PERF_W-1:0]  stall_cycles
);

  localparam logic BRANCH_CHECK_EX = (BRANCH_IN_ID != 0);

  logic [LAT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] var_bits;

  logic             ex_wr_q;
  logic [REG_W-1:0] ex_rd_q;

  logic             raw1, raw2, raw, waw, structural, stall, issue;
  logic             branch_ex;
  logic [LAT_W-1:0] load_cnt;

  // x0 is hardwired: never pending.
  assign cnt[0]      = '0;
  assign var_bits[0] = 1'b0;

  assign load_cnt = id_var_lat ? '0 : id_latency;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_entry
      scoreboard_entry #(
        .LAT_W (LAT_W)
      ) u_entry (
        .clk      (clk),
        .rst      (rst),
        .clr      (wb_done && (wb_rd == REG_W'(gi))),
        .load     (issue && id_reg_write && (id_rd == REG_W'(gi))),
        .load_cnt (load_cnt),
        .load_var (id_var_lat),
        .cnt      (cnt[gi]),
        .is_var   (var_bits[gi])
      );
    end
  endgenerate

  // With branches resolving in ID there is no EX->ID forwarding path, so a
  // producer sitting in EX is still a hazard even though its count is zero.
  assign branch_ex = BRANCH_CHECK_EX && id_is_branch && ex_wr_q;

  always_comb begin
    raw1 = 1'b0;
    raw2 = 1'b0;
    if (id_uses_rs1 && id_rs1 != '0) begin
      raw1 = (cnt[id_rs1] != '0) || var_bits[id_rs1] ||
             (branch_ex && ex_rd_q == id_rs1);
    end
    if (id_uses_rs2 && id_rs2 != '0) begin
      raw2 = (cnt[id_rs2] != '0) || var_bits[id_rs2] ||
             (branch_ex && ex_rd_q == id_rs2);
    end
  end

  assign raw = raw1 || raw2;

  // A write may overtake an older producer only if it finishes no earlier.
  assign waw = id_reg_write && (id_rd != '0) &&
               (var_bits[id_rd] || (cnt[id_rd] > id_latency));

  assign structural = id_uses_mdu && mdu_busy;

  assign stall = id_valid && !flush_id && (raw || waw || structural);
  assign issue = id_valid && !flush_id && !stall;

  assign stall_pc    = stall;
  assign stall_if_id = stall;
  assign flush_id_ex = stall;

  always_comb begin
    stall_cause               = '0;
    stall_cause[CAUSE_RAW]    = stall && raw;
    stall_cause[CAUSE_WAW]    = stall && waw;
    stall_cause[CAUSE_STRUCT] = stall && structural;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_wr_q      <= 1'b0;
      ex_rd_q      <= '0;
      stall_cycles <= '0;
    end else begin
      ex_wr_q <= issue && id_reg_write && (id_rd != '0);
      ex_rd_q <= id_rd;
      if (stall) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        id_uses_rs1, id_uses_rs2, id_is_branch, id_reg_write;
  logic [2:0]  id_latency;
  logic        id_var_lat, id_uses_mdu, mdu_busy, wb_done, flush_id;
  logic        stall_pc, stall_if_id, flush_id_ex;
  logic [2:0]  stall_cause;
  logic [31:0] stall_cycles;

  logic [5:0]  obs;
  int          vectors;
  int          miscompares;
  logic [31:0] exp_cycles;

  localparam logic [2:0] L_ALU  = 3'(LAT_ALU);
  localparam logic [2:0] L_LOAD = 3'(LAT_LOAD);
  localparam logic [2:0] L_MUL  = 3'(LAT_MUL);

  hazard_scoreboard dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_is_branch (id_is_branch),
    .id_reg_write (id_reg_write),
    .id_rd        (id_rd),
    .id_latency   (id_latency),
    .id_var_lat   (id_var_lat),
    .id_uses_mdu  (id_uses_mdu),
    .mdu_busy     (mdu_busy),
    .wb_done      (wb_done),
    .wb_rd        (wb_rd),
    .flush_id     (flush_id),
    .stall_pc     (stall_pc),
    .stall_if_id  (stall_if_id),
    .flush_id_ex  (flush_id_ex),
    .stall_cause  (stall_cause),
    .stall_cycles (stall_cycles)
  );

  assign obs = {stall_pc, stall_if_id, flush_id_ex, stall_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_is_branch = 0; id_reg_write = 0; id_rd = 0; id_latency = 0;
    id_var_lat = 0; id_uses_mdu = 0; mdu_busy = 0; wb_done = 0; wb_rd = 0;
    flush_id = 0;
  endtask

  // Drive a valid instruction into ID, then let the combinational path settle.
  task automatic set_instr(input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic br, input logic wr, input logic [4:0] rd,
                           input logic [2:0] lat, input logic vl,
                           input logic mdu);
    id_valid = 1; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2;
    id_uses_rs2 = u2; id_is_branch = br; id_reg_write = wr; id_rd = rd;
    id_latency = lat; id_var_lat = vl; id_uses_mdu = mdu;
    #1;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 1;
    #2;
    vectors++;
    if (obs !== 6'b000000 || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_in got %b/%0d want 000000/0", obs, stall_cycles);
    end
    tick();
    tick();
    rst = 0;
    tick();
    vectors++;
    if (obs !== 6'b000000 || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_idle got %b/%0d want 000000/0", obs, stall_cycles);
    end
    $display("reset: obs=%b cycles=%0d", obs, stall_cycles);
  endtask

  task automatic test_load_use();
    set_instr(0, 0, 0, 0, 0, 1, 5, L_LOAD, 0, 0);
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL load_issue got %b want 000000", obs);
    end
    tick();
    set_instr(5, 1, 0, 1, 0, 1, 10, L_ALU, 0, 0);
    vectors++;
    if (obs !== 6'b111001) begin
      miscompares++;
      $display("FAIL load_use_stall got %b want 111001", obs);
    end
    tick();
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL load_use_issue got %b want 000000", obs);
    end
    tick();
    clear_in();
    exp_cycles += 1;
    vectors++;
    if (stall_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL load_use_perf got %0d want %0d", stall_cycles, exp_cycles);
    end
    $display("load_use: cycles=%0d", stall_cycles);
  endtask

  task automatic test_mul();
    set_instr(0, 0, 0, 0, 0, 1, 7, L_MUL, 0, 0);
    tick();
    set_instr(7, 1, 0, 0, 0, 1, 8, L_ALU, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs !== 6'b111001) begin
        miscompares++;
        $display("FAIL mul_stall%0d got %b want 111001", i, obs);
      end
      tick();
    end
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL mul_issue got %b want 000000", obs);
    end
    tick();
    clear_in();
    exp_cycles += 3;
    vectors++;
    if (stall_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL mul_perf got %0d want %0d", stall_cycles, exp_cycles);
    end
    $display("mul: cycles=%0d", stall_cycles);
  endtask

  task automatic test_div();
    set_instr(0, 0, 0, 0, 0, 1, 9, 3'd0, 1, 1);
    tick();
    set_instr(0, 0, 9, 1, 0, 1, 14, L_ALU, 0, 0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs !== 6'b111001) begin
        miscompares++;
        $display("FAIL div_wait%0d got %b want 111001", i, obs);
      end
      tick();
    end
    wb_done = 1; wb_rd = 9;
    #1;
    vectors++;
    if (obs !== 6'b111001) begin
      miscompares++;
      $display("FAIL div_wb_cycle got %b want 111001", obs);
    end
    tick();
    wb_done = 0;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL div_after_wb got %b want 000000", obs);
    end
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 11, 3'd0, 1, 1);
    mdu_busy = 1;
    #1;
    vectors++;
    if (obs !== 6'b111100) begin
      miscompares++;
      $display("FAIL mdu_struct got %b want 111100", obs);
    end
    tick();
    clear_in();
    exp_cycles += 6;
    vectors++;
    if (stall_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL div_perf got %0d want %0d", stall_cycles, exp_cycles);
    end
    $display("div: cycles=%0d", stall_cycles);
  endtask

  task automatic test_branch();
    set_instr(0, 0, 0, 0, 0, 1, 3, L_ALU, 0, 0);
    tick();
    set_instr(3, 1, 0, 0, 1, 0, 0, 3'd0, 0, 0);
    vectors++;
    if (obs !== 6'b111001) begin
      miscompares++;
      $display("FAIL branch_ex_stall got %b want 111001", obs);
    end
    tick();
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL branch_issue got %b want 000000", obs);
    end
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 3, L_ALU, 0, 0);
    tick();
    set_instr(3, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL alu_fwd got %b want 000000", obs);
    end
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 0, L_LOAD, 0, 0);
    tick();
    set_instr(0, 1, 0, 1, 1, 0, 0, 3'd0, 0, 0);
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL x0_read got %b want 000000", obs);
    end
    tick();
    clear_in();
    exp_cycles += 1;
    vectors++;
    if (stall_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL branch_perf got %0d want %0d", stall_cycles, exp_cycles);
    end
    $display("branch: cycles=%0d", stall_cycles);
  endtask

  task automatic test_waw();
    set_instr(0, 0, 0, 0, 0, 1, 4, 3'd0, 1, 0);
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 4, L_LOAD, 0, 0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs !== 6'b111010) begin
        miscompares++;
        $display("FAIL waw_var%0d got %b want 111010", i, obs);
      end
      tick();
    end
    wb_done = 1; wb_rd = 4;
    #1;
    vectors++;
    if (obs !== 6'b111010) begin
      miscompares++;
      $display("FAIL waw_wb_cycle got %b want 111010", obs);
    end
    tick();
    wb_done = 0;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL waw_issue got %b want 000000", obs);
    end
    tick();
    clear_in();
    tick();
    // New var producer to x4 issues while a stale wb_done to x4 arrives.
    set_instr(0, 0, 0, 0, 0, 1, 4, 3'd0, 1, 0);
    wb_done = 1; wb_rd = 4;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL same_cycle_issue got %b want 000000", obs);
    end
    tick();
    wb_done = 0;
    set_instr(4, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    vectors++;
    if (obs !== 6'b111001) begin
      miscompares++;
      $display("FAIL load_beats_clear got %b want 111001", obs);
    end
    tick();
    wb_done = 1; wb_rd = 4;
    #1;
    vectors++;
    if (obs !== 6'b111001) begin
      miscompares++;
      $display("FAIL x4_wb_cycle got %b want 111001", obs);
    end
    tick();
    wb_done = 0;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL x4_retired got %b want 000000", obs);
    end
    tick();
    // Equal remaining latency may overtake; shorter may not.
    set_instr(0, 0, 0, 0, 0, 1, 12, L_MUL, 0, 0);
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 12, L_MUL, 0, 0);
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL waw_equal got %b want 000000", obs);
    end
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 12, 3'd2, 0, 0);
    vectors++;
    if (obs !== 6'b111010) begin
      miscompares++;
      $display("FAIL waw_shorter got %b want 111010", obs);
    end
    tick();
    clear_in();
    exp_cycles += 6;
    vectors++;
    if (stall_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL waw_perf got %0d want %0d", stall_cycles, exp_cycles);
    end
    $display("waw: cycles=%0d", stall_cycles);
  endtask

  task automatic test_flush();
    set_instr(0, 0, 0, 0, 0, 1, 13, L_MUL, 0, 0);
    tick();
    set_instr(13, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    flush_id = 1;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL flush_no_stall got %b want 000000", obs);
    end
    tick();
    clear_in();
    vectors++;
    if (stall_cycles !== exp_cycles) begin
      miscompares++;
      $display("FAIL flush_perf got %0d want %0d", stall_cycles, exp_cycles);
    end
    $display("flush: cycles=%0d", stall_cycles);
  endtask

  task automatic test_reset_mid();
    repeat (4) tick();
    set_instr(0, 0, 0, 0, 0, 1, 9, 3'd0, 1, 0);
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 6, 3'd2, 0, 0);
    tick();
    set_instr(6, 1, 9, 1, 0, 0, 0, 3'd0, 0, 0);
    vectors++;
    if (obs !== 6'b111001) begin
      miscompares++;
      $display("FAIL pre_reset got %b want 111001", obs);
    end
    rst = 1;
    #1;
    vectors++;
    if (obs !== 6'b000000 || stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset got %b/%0d want 000000/0", obs, stall_cycles);
    end
    #1;
    rst = 0;
    tick();
    wb_done = 1; wb_rd = 9;
    #1;
    vectors++;
    if (obs !== 6'b000000) begin
      miscompares++;
      $display("FAIL post_reset got %b want 000000", obs);
    end
    tick();
    clear_in();
    vectors++;
    if (stall_cycles !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_perf got %0d want 0", stall_cycles);
    end
    $display("reset_mid: obs=%b cycles=%0d", obs, stall_cycles);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cycles  = 0;
    test_reset();
    test_load_use();
    test_mul();
    test_div();
    test_branch();
    test_waw();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
